// File: rtl/gray_decoder_tracker.sv
// Gray-code sample decoder with up/down/illegal classification and position tracking.
// Define GRAY_DEC_SYNC_EN to add a two-flop input synchronizer ahead of capture.
module gray_decoder_tracker #(
  parameter int N  = 4,
  parameter int PW = N + 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample_en,
  input  logic [N-1:0]  gray_in,
  input  logic          clr_err,
  output logic [N-1:0]  bin_out,
  output logic          valid,
  output logic          step_up,
  output logic          step_dn,
  output logic          err,
  output logic [7:0]    err_cnt,
  output logic [PW-1:0] pos
);

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    FAULT
  } state_t;

  logic [N-1:0] g_s;
  logic         se_s;

`ifdef GRAY_DEC_SYNC_EN
  logic [N-1:0] g_m;
  logic         se_m;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_m  <= '0;
      se_m <= 1'b0;
      g_s  <= '0;
      se_s <= 1'b0;
    end else begin
      g_m  <= gray_in;
      se_m <= sample_en;
      g_s  <= g_m;
      se_s <= se_m;
    end
  end
`else
  assign g_s  = gray_in;
  assign se_s = sample_en;
`endif

  logic [N-1:0] g_q;
  logic         s_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_q <= '0;
      s_q <= 1'b0;
    end else begin
      s_q <= se_s;
      if (se_s) g_q <= g_s;
    end
  end

  // Each binary bit is the XOR of all Gray bits at or above it
  logic [N-1:0] b;
  for (genvar i = 0; i < N; i++) begin : g_dec
    assign b[i] = ^(g_q >> i);
  end

  state_t       state_q, state_d;
  logic [N-1:0] ref_q, ref_d;
  logic [N-1:0] d;
  logic         d_none, d_up, d_dn;

  assign d      = b - ref_q;
  assign d_none = (d == '0);
  assign d_up   = (d == {{(N-1){1'b0}}, 1'b1});
  assign d_dn   = (d == '1);

  logic [N-1:0]  bin_d;
  logic          valid_d, up_d, dn_d, err_d;
  logic [7:0]    cnt_d;
  logic [PW-1:0] pos_d;

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    bin_d   = bin_out;
    valid_d = valid;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    err_d   = err;
    cnt_d   = err_cnt;
    pos_d   = pos;
    if (s_q) begin
      bin_d   = b;
      valid_d = 1'b1;
      ref_d   = b;
      unique case (state_q)
        IDLE: state_d = TRACK;
        TRACK: begin
          if (d_up) begin
            up_d  = 1'b1;
            pos_d = pos + 1'b1;
          end else if (d_dn) begin
            dn_d  = 1'b1;
            pos_d = pos - 1'b1;
          end else if (!d_none) begin
            err_d   = 1'b1;
            state_d = FAULT;
            if (err_cnt != 8'hFF) cnt_d = err_cnt + 8'd1;
          end
        end
        FAULT: begin
          if (clr_err) begin
            err_d   = 1'b0;
            state_d = TRACK;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q == FAULT && clr_err) begin
      err_d   = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ref_q   <= '0;
      bin_out <= '0;
      valid   <= 1'b0;
      step_up <= 1'b0;
      step_dn <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
      pos     <= '0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      bin_out <= bin_d;
      valid   <= valid_d;
      step_up <= up_d;
      step_dn <= dn_d;
      err     <= err_d;
      err_cnt <= cnt_d;
      pos     <= pos_d;
    end
  end

endmodule

// File: tb/tb_gray_decoder_tracker.sv
// Randomized and directed bench for gray_decoder_tracker against
// a transition-rule reference model.
module tb_gray_decoder_tracker;

  localparam int N    = 4;
  localparam int PW   = 8;
  localparam int MASK = (1 << N) - 1;
  localparam int W    = N + 12 + PW;
`ifdef GRAY_DEC_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_en;
  logic [N-1:0]  gray_in;
  logic          clr_err;
  logic [N-1:0]  bin_out;
  logic          valid, step_up, step_dn, err;
  logic [7:0]    err_cnt;
  logic [PW-1:0] pos;

  int checks = 0;
  int errors = 0;

  gray_decoder_tracker #(.N(N), .PW(PW)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en),
    .gray_in(gray_in), .clr_err(clr_err),
    .bin_out(bin_out), .valid(valid),
    .step_up(step_up), .step_dn(step_dn),
    .err(err), .err_cnt(err_cnt), .pos(pos)
  );

  always #5 clk = ~clk;

  // Reference model: states 0=idle 1=track 2=fault
  int            m_st;
  logic [N-1:0]  m_ref, m_bin;
  logic          m_valid, m_up, m_dn, m_err;
  logic [7:0]    m_cnt;
  logic [PW-1:0] m_pos;
  logic [N:0]    dq[$];
  logic          cap_v;
  logic [N-1:0]  cap_g;

  function automatic int g2b(int g);
    int r = 0;
    for (int x = g; x != 0; x = x >> 1) r = r ^ x;
    return r & MASK;
  endfunction

  function automatic logic [N-1:0] b2g(int x);
    return N'((x ^ (x >> 1)) & MASK);
  endfunction

  function automatic logic [W-1:0] obs();
    return {bin_out, valid, step_up, step_dn, err, err_cnt, pos};
  endfunction

  function automatic logic [W-1:0] expv();
    return {m_bin, m_valid, m_up, m_dn, m_err, m_cnt, m_pos};
  endfunction

  task automatic model_reset();
    m_st = 0; m_ref = '0; m_bin = '0;
    m_valid = 0; m_up = 0; m_dn = 0; m_err = 0;
    m_cnt = '0; m_pos = '0;
    cap_v = 0; cap_g = '0;
    dq.delete();
    for (int i = 0; i < LAT - 1; i++) dq.push_back('0);
  endtask

  task automatic model_edge();
    int b, d;
    logic [N:0] e;
    m_up = 0; m_dn = 0;
    if (cap_v) begin
      b = g2b(int'(cap_g));
      d = (b - int'(m_ref)) & MASK;
      m_bin = N'(b); m_valid = 1;
      if (m_st == 0) m_st = 1;
      else if (m_st == 1) begin
        if (d == 1) begin m_up = 1; m_pos = m_pos + 1; end
        else if (d == MASK) begin m_dn = 1; m_pos = m_pos - 1; end
        else if (d != 0) begin
          m_err = 1; m_st = 2;
          if (m_cnt < 255) m_cnt = m_cnt + 1;
        end
      end else if (clr_err) begin
        m_err = 0; m_st = 1;
      end
      m_ref = N'(b);
    end else if (m_st == 2 && clr_err) begin
      m_err = 0; m_st = 0;
    end
    dq.push_back({sample_en, gray_in});
    e = dq.pop_front();
    cap_v = e[N];
    if (e[N]) cap_g = e[N-1:0];
  endtask

  task automatic step(input logic [N-1:0] g, input logic en, input logic clr);
    gray_in = g; sample_en = en; clr_err = clr;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic flush();
    repeat (LAT) step(gray_in, 1'b0, 1'b0);
  endtask

  task automatic sample(input int x);
    step(b2g(x), 1'b1, 1'b0);
    flush();
  endtask

  task automatic sample_clr(input int x);
    step(b2g(x), 1'b1, 1'b0);
    repeat (LAT - 1) step(b2g(x), 1'b0, 1'b0);
    step(b2g(x), 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sample_en = 0; gray_in = '0; clr_err = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs() !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h want 0", obs());
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_first_up();
    sample(0);
    checks++;
    if (obs() !== expv() || valid !== 1'b1 || bin_out !== 4'd0 || step_up !== 1'b0) begin
      errors++;
      $display("FAIL first_ref: got %h want %h", obs(), expv());
    end
    sample(1);
    checks++;
    if (obs() !== expv() || step_up !== 1'b1 || pos !== 8'd1 || bin_out !== 4'd1) begin
      errors++;
      $display("FAIL first_up: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_wrap();
    int ups = 0;
    do_reset();
    step(b2g(0), 1'b1, 1'b0);
    for (int i = 1; i <= 16 + LAT; i++) begin
      if (i <= 16) step(b2g(i % 16), 1'b1, 1'b0);
      else step(gray_in, 1'b0, 1'b0);
      if (step_up === 1'b1) ups++;
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL wrap_cycle%0d: got %h want %h", i, obs(), expv());
      end
    end
    checks++;
    if (ups != 16 || pos !== 8'd16 || bin_out !== 4'd0) begin
      errors++;
      $display("FAIL wrap_total: got ups=%0d pos=%0d want 16 16", ups, pos);
    end
  endtask

  task automatic test_dn();
    do_reset();
    sample(0);
    sample(15);
    checks++;
    if (obs() !== expv() || bin_out !== 4'd15 || step_dn !== 1'b1 || pos !== 8'hFF) begin
      errors++;
      $display("FAIL down_step: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_illegal();
    do_reset();
    sample(0);
    sample(2);
    checks++;
    if (obs() !== expv() || err !== 1'b1 || err_cnt !== 8'd1 || bin_out !== 4'd2 ||
        step_up !== 1'b0) begin
      errors++;
      $display("FAIL illegal: got %h want %h", obs(), expv());
    end
    sample(1);
    sample(2);
    checks++;
    if (obs() !== expv() || step_dn !== 1'b0 || step_up !== 1'b0 || pos !== 8'd0) begin
      errors++;
      $display("FAIL fault_frozen: got %h want %h", obs(), expv());
    end
    sample_clr(3);
    checks++;
    if (obs() !== expv() || err !== 1'b0 || step_up !== 1'b0 || bin_out !== 4'd3) begin
      errors++;
      $display("FAIL clr_with_sample: got %h want %h", obs(), expv());
    end
    sample(4);
    checks++;
    if (obs() !== expv() || step_up !== 1'b1 || pos !== 8'd1) begin
      errors++;
      $display("FAIL after_clr_up: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_repeat_idle();
    do_reset();
    step(b2g(5), 1'b1, 1'b0);
    for (int i = 0; i < 3 + LAT; i++) begin
      step(b2g(5), i < 3, 1'b0);
      checks++;
      if (obs() !== expv() || step_up || step_dn || err) begin
        errors++;
        $display("FAIL repeat_value%0d: got %h want %h", i, obs(), expv());
      end
    end
    for (int i = 0; i < 6; i++) begin
      step(N'($urandom), 1'b0, 1'b0);
      checks++;
      if (obs() !== expv() || bin_out !== 4'd5) begin
        errors++;
        $display("FAIL no_enable%0d: got %h want %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i <= 5; i++) step(b2g(i), 1'b1, 1'b0);
    step(b2g(8), 1'b1, 1'b0);
    flush();
    step(gray_in, 1'b0, 1'b1);
    sample(8);
    sample(11);
    step(gray_in, 1'b0, 1'b1);
    sample(11);
    sample(14);
    checks++;
    if (obs() !== expv() || pos !== 8'd5 || err_cnt !== 8'd3 || err !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_state: got %h want %h", obs(), expv());
    end
    step(b2g(15), 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (obs() !== '0) begin
      errors++;
      $display("FAIL async_reset: got %h want 0", obs());
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 1) step(gray_in, 1'b0, 1'b0);
    checks++;
    if (obs() !== expv() || valid !== 1'b0) begin
      errors++;
      $display("FAIL inflight_dropped: got %h want %h", obs(), expv());
    end
    sample(9);
    checks++;
    if (obs() !== expv() || valid !== 1'b1 || step_up || step_dn || bin_out !== 4'd9) begin
      errors++;
      $display("FAIL post_reset_ref: got %h want %h", obs(), expv());
    end
    sample(10);
    checks++;
    if (obs() !== expv() || step_up !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_up: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_saturate();
    int cur = 0;
    do_reset();
    sample(0);
    for (int i = 0; i < 260; i++) begin
      cur = (cur + 2) & MASK;
      step(b2g(cur), 1'b1, 1'b0);
      sample_clr(cur);
    end
    sample((cur + 2) & MASK);
    checks++;
    if (obs() !== expv() || err_cnt !== 8'hFF || err !== 1'b1) begin
      errors++;
      $display("FAIL err_saturate: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_random();
    int cur = 0;
    int r;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4) cur = cur + 1;
      else if (r < 7) cur = cur - 1;
      else if (r > 7) cur = $urandom_range(0, MASK);
      cur = cur & MASK;
      step(b2g(cur), $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
      checks++;
      if (obs() !== expv() || (step_up && step_dn)) begin
        errors++;
        $display("FAIL random%0d: got %h want %h", i, obs(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_up();
    test_wrap();
    test_dn();
    test_illegal();
    test_repeat_idle();
    test_async_reset();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_decoder_tracker.md
# gray_decoder_tracker

Receiving end of the Gray-count path. Samples an N-bit Gray-coded value, such as the output of the team's Gray counter or a rotary/position encoder, when qualified by a sample-enable pulse. It converts each sample to binary and classifies each transition against the previous accepted sample as up, down, none or illegal. It maintains a signed position accumulator and an error state with a saturating error count, for use by downstream position/rate logic.

## Interface
- N, default 4: Gray/binary width; legal range N ≥ 2.
- PW, default N+4: position accumulator width.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- sample_en  in  1  qualifies gray_in for capture on this edge; single- or multi-cycle assertion allowed.
- gray_in  in  N  Gray-coded input value.
- clr_err  in  1  clears the fault state; sampled on the edge.
- bin_out  out  N  binary value of the last decoded sample.
- valid  out  1  high once at least one sample has been decoded since reset.
- step_up  out  1  one-cycle pulse for a +1 transition.
- step_dn  out  1  one-cycle pulse for a −1 transition.
- err  out  1  level; high while in FAULT.
- err_cnt  out  8  count of illegal transitions; saturates at 255.
- pos  out  PW  two's-complement position; wraps modulo 2^PW.

## Operation
- Stage 1 (capture): on an edge with sample_en=1, register gray_in into g_q and set s_q=1; otherwise s_q=0.
- Stage 2 (decode): binary b is computed combinationally from g_q as b[N-1]=g_q[N-1] and b[i]=b[i+1]^g_q[i]. When s_q=1, the action depends on state; b is always written to bin_out and valid is set to 1.
- Transition class: d=(b − ref) mod 2^N, where ref is the previous accepted binary value.
  - d=0: NONE.
  - d=1: UP.
  - d=2^N−1: DN.
  - Any other d: ILLEGAL.
- States:
  - IDLE (reset state): a decoded sample loads ref=b, produces no pulse, and moves to TRACK.
  - TRACK: UP → step_up=1, pos+1. DN → step_dn=1, pos−1. NONE → nothing. ILLEGAL → err=1, err_cnt+1 (saturating), no pulse, pos unchanged, move to FAULT. In every case ref=b.
  - FAULT: samples still update bin_out and ref; there are no pulses, pos is frozen, and err_cnt does not increment. clr_err=1 moves to IDLE and drops err.
- clr_err in IDLE or TRACK has no effect.
- Simultaneous clr_err and a decoded sample in FAULT: that sample becomes the new ref with no pulse, next state is TRACK, and err=0.
- step_up and step_dn are never high together.
- pos wraps silently: max+1 → min, min−1 → max.

## Timing
- Latency: a sample captured on edge k produces its outputs after edge k+1. With the synchronizer option (see Configuration), outputs appear after edge k+3 relative to the edge on which gray_in/sample_en were first sampled.
- Back-to-back samples (sample_en held high) are decoded one per cycle.
- Reset values: bin_out=0, valid=0, step_up=0, step_dn=0, err=0, err_cnt=0, pos=0, state=IDLE, ref=0, all pipeline flops 0.
- Reset takes effect immediately (asynchronous) and discards any in-flight sample.

## Configuration
- GRAY_DEC_SYNC_EN defined: gray_in and sample_en each pass through a free-running two-flop synchronizer ahead of stage 1. Both paths have equal delay, so sample alignment is preserved. Latency increases by 2 cycles; the synchronizer flops reset to 0.
- GRAY_DEC_SYNC_EN undefined: stage 1 samples the ports directly. The caller must then guarantee gray_in is synchronous to clk.

## Test plan
- Reset, then sample 0000 → valid=1, bin_out=0, no pulse. Then sample 0001 → bin_out=1, step_up pulse, pos=1.
- Sixteen successive up-steps from 0000 through 1000 back to 0000 → sixteen step_up pulses, bin_out wraps 15→0, pos=16 (PW=8).
- From reference 0000, sample 1000 → bin_out=15, step_dn pulse, pos=0xFF.
- From 0000, sample 0011 → bin_out=2, err=1, err_cnt=1, no pulse. Further legal steps produce no pulses and pos stays unchanged. Assert clr_err together with sample 0010 → err=0, ref=3, no pulse. Next sample 0110 → step_up.
- Repeat the same Gray value with sample_en=1 → no pulse and no error. Toggle gray_in with sample_en=0 → all outputs unchanged.
- Assert rst mid-stream with pos=5, err_cnt=3, in FAULT → all outputs 0 immediately, before the next clk edge. The first sample after release is a no-pulse reference.
